nv_nvdla_rubik_pingpong_ctrl: RTL and testbench

Ping-pong layer sequencer for RUBIK, directly downstream of the RUBIK single-register block. It consumes the software `producer` pointer and per-group op_en writes, and tracks which of the two register groups is idle, pending or running. It returns `consumer`, `status_0` and `status_1` to the single-register block for readback. Toward the RUBIK datapath it drives op_en and layer-start; toward the CSB/GLB it drives the op_en clear and done-interrupt pulses.

---
 rtl/nv_nvdla_rubik_pp_pkg.sv | 23 ++
 rtl/nv_nvdla_rubik_grp_fsm.sv | 57 +++++
 rtl/nv_nvdla_rubik_pingpong_ctrl.sv | 92 +++++++++
 tb/tb_nv_nvdla_rubik_pingpong_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_rubik_pp_pkg.sv
// Shared definitions for the RUBIK ping-pong layer sequencer.
// Holds the group status encoding, status width, group count and group index type.
package nv_nvdla_rubik_pp_pkg;

   localparam int unsigned GRP_NUM = 2;
   localparam int unsigned ST_W    = 2;

   // Status encoding seen by software through status_0/status_1; 2'd3 is never produced.
   localparam logic [ST_W-1:0] RBK_ST_IDLE = 2'd0;
   localparam logic [ST_W-1:0] RBK_ST_PEND = 2'd1;
   localparam logic [ST_W-1:0] RBK_ST_RUN  = 2'd2;

   // One bit selects between the two register groups.
   typedef logic grp_idx_t;

   // Per-group FSM state, encoded identically to the readback status.
   typedef enum logic [ST_W-1:0] {
      GRP_IDLE = RBK_ST_IDLE,
      GRP_PEND = RBK_ST_PEND,
      GRP_RUN  = RBK_ST_RUN
   } grp_st_e;

endpackage

// File: rtl/nv_nvdla_rubik_grp_fsm.sv
// Status tracker for one RUBIK register group (IDLE -> PENDING -> RUNNING -> IDLE).
// Ports:
//   nvdla_core_clk, nvdla_core_rstn : clock, async active-low reset
//   set    : op_en write targeting this group this cycle
//   launch : top-level grant to start this group this cycle
//   done   : datapath finished this group's layer this cycle
//   status : registered group status (readback encoding)
//   err_c  : combinational, high when this cycle's set is rejected
module nv_nvdla_rubik_grp_fsm
   import nv_nvdla_rubik_pp_pkg::*;
(
   input  logic            nvdla_core_clk,
   input  logic            nvdla_core_rstn,
   input  logic            set,
   input  logic            launch,
   input  logic            done,
   output logic [ST_W-1:0] status,
   output logic            err_c
);

   grp_st_e state_q;
   grp_st_e state_d;

   // State register.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q <= GRP_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and write-rejection logic. A done is applied before a set in the
   // same cycle, so a re-arm of the finishing group lands in PENDING without error.
   always_comb begin
      state_d = state_q;
      err_c   = 1'b0;
      case (state_q)
         GRP_IDLE: begin
            // launch may accompany set: the group skips visible PENDING.
            if (set) state_d = launch ? GRP_RUN : GRP_PEND;
         end
         GRP_PEND: begin
            if (launch) state_d = GRP_RUN;
            err_c = set;
         end
         GRP_RUN: begin
            if (done) state_d = set ? GRP_PEND : GRP_IDLE;
            else      err_c   = set;
         end
         default: state_d = GRP_IDLE;
      endcase
   end

   assign status = state_q;

endmodule

// File: rtl/nv_nvdla_rubik_pingpong_ctrl.sv
// RUBIK ping-pong layer sequencer: tracks which of the two register groups is
// idle, pending or running, picks the next layer to launch, and produces the
// datapath enable, layer-start, op_en clear, done interrupt and op_en error pulses.
// Ports:
//   nvdla_core_clk, nvdla_core_rstn : clock, async active-low reset
//   producer            : software group pointer, only used for the ordering check
//   op_en_wr, op_en_grp : op_en=1 write pulse and its target group
//   dp_done             : datapath finished the running layer
//   consumer            : group executed next or now
//   status_0, status_1  : per-group status readback
//   dp_op_en, dp_grp    : datapath enable level and running group index
//   layer_start         : pulse on each launch
//   op_en_clr, done_intr: one-hot pulses for the finished group
//   op_en_err           : pulse on an illegal or out-of-order op_en write
module nv_nvdla_rubik_pingpong_ctrl
   import nv_nvdla_rubik_pp_pkg::*;
(
   input  logic               nvdla_core_clk,
   input  logic               nvdla_core_rstn,
   input  logic               producer,
   input  logic               op_en_wr,
   input  logic               op_en_grp,
   input  logic               dp_done,
   output logic               consumer,
   output logic [ST_W-1:0]    status_0,
   output logic [ST_W-1:0]    status_1,
   output logic               dp_op_en,
   output logic               dp_grp,
   output logic               layer_start,
   output logic [GRP_NUM-1:0] op_en_clr,
   output logic [GRP_NUM-1:0] done_intr,
   output logic               op_en_err
);

   logic [ST_W-1:0]    st [GRP_NUM];
   logic [GRP_NUM-1:0] set;
   logic [GRP_NUM-1:0] launch;
   logic [GRP_NUM-1:0] done;
   logic [GRP_NUM-1:0] err_c;
   logic [GRP_NUM-1:0] running;
   logic [GRP_NUM-1:0] pending;
   logic [GRP_NUM-1:0] idle;

   for (genvar g = 0; g < GRP_NUM; g++) begin : g_grp
      assign running[g] = (st[g] == RBK_ST_RUN);
      assign pending[g] = (st[g] == RBK_ST_PEND);
      assign idle[g]    = (st[g] == RBK_ST_IDLE);

      assign set[g]  = op_en_wr & (op_en_grp == grp_idx_t'(g));
      assign done[g] = dp_done & running[g];

      // Launch looks only at registered state: a finishing layer toggles consumer
      // first, so the other group starts one cycle later (the dp_op_en bubble).
      assign launch[g] = (pending[g] | (idle[g] & set[g]))
                       & (consumer == grp_idx_t'(g))
                       & ~running[GRP_NUM-1-g];

      nv_nvdla_rubik_grp_fsm u_grp_fsm (
         .nvdla_core_clk  (nvdla_core_clk),
         .nvdla_core_rstn (nvdla_core_rstn),
         .set             (set[g]),
         .launch          (launch[g]),
         .done            (done[g]),
         .status          (st[g]),
         .err_c           (err_c[g])
      );
   end

   // Consumer pointer and registered output pulses.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         consumer    <= 1'b0;
         dp_op_en    <= 1'b0;
         layer_start <= 1'b0;
         op_en_clr   <= '0;
         done_intr   <= '0;
         op_en_err   <= 1'b0;
      end else begin
         if (|done) consumer <= ~consumer;
         dp_op_en    <= (|launch) | ((|running) & ~dp_done);
         layer_start <= |launch;
         op_en_clr   <= done;
         done_intr   <= done;
         op_en_err   <= (|err_c) | (op_en_wr & (op_en_grp != producer));
      end
   end

   assign dp_grp   = consumer;
   assign status_0 = st[0];
   assign status_1 = st[1];

endmodule

// File: tb/tb_nv_nvdla_rubik_pingpong_ctrl.sv
// Self-checking bench for the RUBIK ping-pong layer sequencer.
module tb_nv_nvdla_rubik_pingpong_ctrl;

   logic       nvdla_core_clk;
   logic       nvdla_core_rstn;
   logic       producer;
   logic       op_en_wr;
   logic       op_en_grp;
   logic       dp_done;
   logic       consumer;
   logic [1:0] status_0;
   logic [1:0] status_1;
   logic       dp_op_en;
   logic       dp_grp;
   logic       layer_start;
   logic [1:0] op_en_clr;
   logic [1:0] done_intr;
   logic       op_en_err;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: status per group (0 idle, 1 pending, 2 running),
   // consumer pointer and the outputs expected after the last clock edge.
   int         m_st [2];
   logic       m_cons;
   logic       e_start;
   logic [1:0] e_clr;
   logic       e_err;

   nv_nvdla_rubik_pingpong_ctrl dut (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .producer        (producer),
      .op_en_wr        (op_en_wr),
      .op_en_grp       (op_en_grp),
      .dp_done         (dp_done),
      .consumer        (consumer),
      .status_0        (status_0),
      .status_1        (status_1),
      .dp_op_en        (dp_op_en),
      .dp_grp          (dp_grp),
      .layer_start     (layer_start),
      .op_en_clr       (op_en_clr),
      .done_intr       (done_intr),
      .op_en_err       (op_en_err)
   );

   initial nvdla_core_clk = 1'b0;
   always #5 nvdla_core_clk = ~nvdla_core_clk;

   // Output bundle: {consumer, status_0, status_1, dp_op_en, dp_grp, layer_start, op_en_clr, done_intr, op_en_err}
   function automatic logic [12:0] pk(logic c, logic [1:0] s0, logic [1:0] s1, logic en, logic gp,
                                      logic ls, logic [1:0] clr, logic [1:0] intr, logic er);
      return {c, s0, s1, en, gp, ls, clr, intr, er};
   endfunction

   function automatic logic [12:0] obs();
      return pk(consumer, status_0, status_1, dp_op_en, dp_grp, layer_start, op_en_clr, done_intr, op_en_err);
   endfunction

   function automatic logic [12:0] expv();
      logic en;
      en = (m_st[0] == 2) || (m_st[1] == 2);
      return pk(m_cons, 2'(m_st[0]), 2'(m_st[1]), en, m_cons, e_start, e_clr, e_clr, e_err);
   endfunction

   task automatic model_reset();
      m_st[0] = 0; m_st[1] = 0; m_cons = 1'b0;
      e_start = 1'b0; e_clr = 2'b00; e_err = 1'b0;
   endtask

   // One clock of the sequencer rules: done first, then the write against the
   // post-done state, then launch decided from the state before this clock.
   task automatic model_step(input logic wr, input logic grp, input logic prod, input logic dn);
      int   old_st [2];
      logic old_cons;
      old_st[0] = m_st[0]; old_st[1] = m_st[1]; old_cons = m_cons;
      e_start = 1'b0; e_clr = 2'b00; e_err = 1'b0;
      for (int g = 0; g < 2; g++) begin
         if (dn && old_st[g] == 2) begin
            m_st[g]  = 0;
            m_cons   = ~m_cons;
            e_clr[g] = 1'b1;
         end
      end
      if (wr) begin
         if (m_st[grp] != 0) e_err = 1'b1;
         else                m_st[grp] = 1;
         if (grp != prod) e_err = 1'b1;
      end
      for (int g = 0; g < 2; g++) begin
         if (old_st[g] != 2 && m_st[g] == 1 && int'(old_cons) == g && old_st[1-g] != 2) begin
            m_st[g] = 2;
            e_start = 1'b1;
         end
      end
   endtask

   task automatic drive(input logic wr, input logic grp, input logic prod, input logic dn);
      op_en_wr = wr; op_en_grp = grp; producer = prod; dp_done = dn;
      @(posedge nvdla_core_clk); #1;
      model_step(wr, grp, prod, dn);
      op_en_wr = 1'b0; dp_done = 1'b0;
   endtask

   task automatic do_reset();
      op_en_wr = 1'b0; op_en_grp = 1'b0; producer = 1'b0; dp_done = 1'b0;
      nvdla_core_rstn = 1'b0;
      repeat (2) @(posedge nvdla_core_clk);
      #1 nvdla_core_rstn = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (obs() !== pk(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0)) begin
         n_fail++; $display("FAIL reset: got %b want %b", obs(), 13'b0);
      end
   endtask

   task automatic test_single_launch();
      logic [12:0] w;
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      w = pk(1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL launch_grp0: got %b want %b", obs(), w); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      w = pk(1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL launch_hold: got %b want %b", obs(), w); end
   endtask

   task automatic test_back_to_back();
      logic [12:0] w;
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      w = pk(1'b0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL b2b_pend1: got %b want %b", obs(), w); end
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      w = pk(1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL b2b_done0: got %b want %b", obs(), w); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      w = pk(1'b1, 2'd0, 2'd2, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL b2b_start1: got %b want %b", obs(), w); end
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      w = pk(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL b2b_done1: got %b want %b", obs(), w); end
   endtask

   task automatic test_wait_pending();
      logic [12:0] w;
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      w = pk(1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (obs() !== w) begin n_fail++; $display("FAIL wait_pend1 cyc%0d: got %b want %b", i, obs(), w); end
         drive(1'b0, 1'b0, 1'b0, 1'b0);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      w = pk(1'b0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL wait_grp0_first: got %b want %b", obs(), w); end
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      w = pk(1'b1, 2'd0, 2'd2, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL wait_grp1_second: got %b want %b", obs(), w); end
   endtask

   task automatic test_op_en_err();
      logic [12:0] w;
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      w = pk(1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL err_busy: got %b want %b", obs(), w); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      w = pk(1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL err_one_cycle: got %b want %b", obs(), w); end
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      w = pk(1'b1, 2'd0, 2'd2, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL err_producer: got %b want %b", obs(), w); end
   endtask

   task automatic test_done_and_write();
      logic [12:0] w;
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      w = pk(1'b1, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL done_and_write: got %b want %b", obs(), w); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      w = pk(1'b1, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL done_and_write_wait: got %b want %b", obs(), w); end
   endtask

   task automatic test_spurious_done();
      logic [12:0] w;
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      w = pk(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL spurious_idle: got %b want %b", obs(), w); end
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      w = pk(1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL spurious_pending: got %b want %b", obs(), w); end
   endtask

   task automatic test_reset_midlayer();
      logic [12:0] w;
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      #2 nvdla_core_rstn = 1'b0;
      #1;
      w = 13'b0;
      n_cmp++;
      if (obs() !== w) begin n_fail++; $display("FAIL rst_async: got %b want %b", obs(), w); end
      @(posedge nvdla_core_clk); #1 nvdla_core_rstn = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0);
         n_cmp++;
         if (obs() !== w) begin n_fail++; $display("FAIL rst_after cyc%0d: got %b want %b", i, obs(), w); end
      end
   endtask

   task automatic test_random();
      logic wr, grp, prod, dn;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         wr   = ($urandom_range(0, 2) == 0);
         grp  = 1'($urandom_range(0, 1));
         prod = ($urandom_range(0, 7) == 0) ? ~grp : grp;
         dn   = ($urandom_range(0, 3) == 0);
         drive(wr, grp, prod, dn);
         n_cmp++;
         if (obs() !== expv()) begin
            n_fail++; $display("FAIL random cyc%0d: got %b want %b", i, obs(), expv());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_launch();
      test_back_to_back();
      test_wait_pending();
      test_op_en_err();
      test_done_and_write();
      test_spurious_done();
      test_reset_midlayer();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
